// File: rtl/param_sequence_detector_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seqdet_pkg;

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  // Width needed to hold a pattern length in the range 0..pat_w.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/param_sequence_detector_if.sv
// Serial data, configuration and match-status signals of the detector.
interface param_sequence_detector_if
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = len_width(PAT_W);

  logic             X;
  logic             x_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cfg_err;
  logic             armed;
  logic             Y;
  logic             Y_reg;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output X, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  cfg_err, armed, Y, Y_reg, match_count, count_sat
  );

  modport slave (
    input  X, x_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output cfg_err, armed, Y, Y_reg, match_count, count_sat
  );
endinterface

// File: rtl/param_sequence_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  // Count up on inc, hold at all-ones; rst and clr zero the count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/param_sequence_detector.sv
// Programmable serial bit-pattern detector with Mealy/Moore match flags
// and a saturating match counter.
module param_sequence_detector
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) (
  input logic                      clk,
  input logic                      rst,
  param_sequence_detector_if.slave bus
);
  localparam int LEN_W = len_width(PAT_W);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  // The newest bit comes from X, so PAT_W-1 stored bits cover the longest pattern.
  logic [PAT_W-2:0] hist_q;
  logic [LEN_W-1:0] fill_q;
  logic [LEN_W-1:0] fill_nxt;
  logic [LEN_W:0]   fill_inc;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] cand;
  logic             cfg_legal;
  logic             cfg_take;
  logic             shift_en;
  logic             eq;
  logic             y;

  assign cfg_legal = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));
  assign cfg_take  = bus.cfg_load && cfg_legal;
  assign shift_en  = (state == ARMED) && bus.x_valid && !bus.cfg_load;
  assign cand      = {hist_q, bus.X};
  assign fill_inc  = {1'b0, fill_q} + 1'b1;

  // Compare the newest len bits against the stored pattern and gate the match.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    eq = (((cand ^ pat_q) & mask) == '0);
    y  = shift_en && eq && (fill_inc >= {1'b0, len_q});

    fill_nxt = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_inc[LEN_W-1:0];
    if (y && !ovl_q) begin
      fill_nxt = '0;
    end
  end

  // Next-state: a legal load always arms; nothing else leaves the current state.
  always_comb begin
    state_nxt = state;
    if (cfg_take) begin
      state_nxt = ARMED;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Configuration, history, fill tracking and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      hist_q      <= '0;
      fill_q      <= '0;
      bus.Y_reg   <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.Y_reg   <= y;
      bus.cfg_err <= bus.cfg_load && !cfg_legal;
      if (cfg_take) begin
        pat_q  <= bus.cfg_pattern;
        len_q  <= bus.cfg_len;
        ovl_q  <= bus.cfg_overlap;
        hist_q <= '0;
        fill_q <= '0;
      end else if (shift_en) begin
        hist_q <= cand[PAT_W-2:0];
        fill_q <= fill_nxt;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cfg_take),
    .inc   (y),
    .count (bus.match_count),
    .sat   (bus.count_sat)
  );

  assign bus.Y     = y;
  assign bus.armed = (state == ARMED);

endmodule
